data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder
//  Purpose  : Single-outstanding data-memory responder for a multicycle
//             datapath. Accepts one load/store, waits LATENCY cycles, then
//             presents a response held until the datapath consumes it.
//             Optional macro DMEM_BOUNDS_CHECK_EN faults addresses beyond the
//             storage array instead of wrapping them.
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_re,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall
);

    localparam int         c_AW  = $clog2(DEPTH);
    localparam logic [3:0] c_LAT = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_accept;
    logic              w_commit;

    logic [63:0]       r_addr;
    logic [63:0]       r_wdata;
    logic              r_re;
    logic              r_we;
    logic [3:0]        r_cnt;
    logic [63:0]       r_rdata;
    logic              r_err;
    logic [63:0]       r_mem [DEPTH];

    // With zero latency the commit happens on the accept edge itself, so the
    // live request inputs are used while idle and the latched copy otherwise.
    logic              w_live;
    logic [63:0]       w_addr;
    logic [63:0]       w_wdata;
    logic              w_re;
    logic              w_we;
    logic [c_AW-1:0]   w_idx;
    logic              w_oob;
    logic              w_err;

    assign w_live  = (r_state == S_IDLE);
    assign w_addr  = w_live ? req_addr  : r_addr;
    assign w_wdata = w_live ? req_wdata : r_wdata;
    assign w_re    = w_live ? req_re    : r_re;
    assign w_we    = w_live ? req_we    : r_we;
    assign w_idx   = w_addr[3+c_AW-1:3];

`ifdef DMEM_BOUNDS_CHECK_EN
    assign w_oob = |w_addr[63:3+c_AW];
`else
    // Upper address bits are dropped: the array aliases modulo DEPTH*8 bytes.
    logic w_unused_hi;
    assign w_unused_hi = |w_addr[63:3+c_AW];
    assign w_oob       = 1'b0;
`endif

    // Misaligned, ambiguous (both/neither op) or out-of-range requests fault.
    assign w_err = (|w_addr[2:0]) | (w_re == w_we) | w_oob;

    // Next-state and commit decode.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (LATENCY == 0) begin
                        w_next   = S_RESP;
                        w_commit = 1'b1;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_next   = S_RESP;
                    w_commit = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State, request latch, wait counter and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= 64'd0;
            r_wdata <= 64'd0;
            r_re    <= 1'b0;
            r_we    <= 1'b0;
            r_cnt   <= 4'd0;
            r_rdata <= 64'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_re    <= req_re;
                r_we    <= req_we;
                r_cnt   <= c_LAT;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                r_err   <= w_err;
                r_rdata <= (!w_err && w_re) ? r_mem[w_idx] : 64'd0;
            end else if ((r_state == S_RESP) && rsp_ready) begin
                r_err   <= 1'b0;
                r_rdata <= 64'd0;
            end
        end
    end

    // Storage array: not reset; a store lands only on a clean commit edge.
    always_ff @(posedge clk) begin
        if (!rst && w_commit && !w_err && w_we) begin
            r_mem[w_idx] <= w_wdata;
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign stall     = ((r_state == S_IDLE) && req_valid) ||
                       (r_state == S_WAIT) ||
                       ((r_state == S_RESP) && !rsp_ready);

endmodule
`default_nettype wire
